// File: rtl/sdcram_sector_cache_pkg.sv
// Shared types and constants for the sdcram single-sector cache.
package sdcram_sector_cache_pkg;
  localparam int SECTOR_WORDS_DEF = 128;
  localparam int ADDR_W_DEF       = 41;
  localparam int WORD_LSB         = 2;
  localparam int SECTOR_LSB       = 9;
  localparam int BLK_SEC_W        = 32;

  typedef enum logic [3:0] {
    IDLE, LOOKUP, WB_REQ, WB_DATA, WB_WAIT,
    FILL_REQ, FILL_DATA, FILL_WAIT, ACCESS
  } state_e;

  typedef struct packed {
    logic        wr;
    logic [3:0]  wen;
    logic [31:0] wdata;
  } req_t;
endpackage

// File: rtl/sdcram_sector_buf.sv
// One-sector buffer: single-port synchronous-read RAM, one byte lane per instance of the lane loop.
module sdcram_sector_buf
  import sdcram_sector_cache_pkg::*;
#(
  parameter int WORDS = SECTOR_WORDS_DEF
) (
  input  logic                       i_clk,
  input  logic [$clog2(WORDS)-1:0]   addr,
  input  logic [3:0]                 we,
  input  logic [31:0]                wdata,
  output logic [31:0]                rdata
);
  for (genvar b = 0; b < 4; b++) begin : g_lane
    logic [7:0] mem [WORDS];
    always_ff @(posedge i_clk) begin
      if (we[b]) mem[addr] <= wdata[b*8 +: 8];
      rdata[b*8 +: 8] <= mem[addr];
    end
  end
endmodule

// File: rtl/sdcram_sector_cache.sv
// sdcram responder caching one 512-byte sector; misses write back (if dirty) and refill
// through a sector-level block backend.
module sdcram_sector_cache
  import sdcram_sector_cache_pkg::*;
#(
  parameter int SECTOR_WORDS = SECTOR_WORDS_DEF,
  parameter int ADDR_W       = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] sdcram_addr,
  input  logic              sdcram_ren,
  input  logic [3:0]        sdcram_wen,
  input  logic [31:0]       sdcram_wdata,
  output logic [31:0]       sdcram_rdata,
  output logic              sdcram_busy,
  output logic              o_blk_rd_req,
  output logic              o_blk_wr_req,
  output logic [31:0]       o_blk_sector,
  input  logic              i_blk_ack,
  input  logic [31:0]       i_blk_rdata,
  input  logic              i_blk_rvalid,
  output logic [31:0]       o_blk_wdata,
  output logic              o_blk_wvalid,
  input  logic              i_blk_wready,
  input  logic              i_blk_done
);
  localparam int IDX_W   = $clog2(SECTOR_WORDS);
  localparam int SEC_LSB = WORD_LSB + IDX_W;
  localparam logic [IDX_W:0] LAST = (IDX_W+1)'(SECTOR_WORDS - 1);

  state_e            state;
  req_t              req;
  logic              valid, dirty, done_seen;
  logic [31:0]       tag, req_sec;
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W:0]    wb_cnt, fill_cnt;
  logic [IDX_W-1:0]  buf_addr;
  logic [3:0]        buf_we;
  logic [31:0]       buf_wdata, buf_rdata;
  logic              accept, hit, wb_adv, fill_wr;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^sdcram_addr[WORD_LSB-1:0];

  assign accept  = (state == IDLE) && !sdcram_busy && (sdcram_ren || (sdcram_wen != 4'b0000));
  assign hit     = valid && (tag == req_sec);
  assign wb_adv  = o_blk_wvalid && i_blk_wready;
  assign fill_wr = (state == FILL_DATA) && i_blk_rvalid && !fill_cnt[IDX_W];
  assign o_blk_wdata = buf_rdata;

  // RAM address steering; write-back looks one word ahead so the output never goes stale
  always_comb begin
    buf_addr  = req_idx;
    buf_we    = 4'b0000;
    buf_wdata = req.wdata;
    case (state)
      IDLE:      buf_addr = sdcram_addr[WORD_LSB +: IDX_W];
      LOOKUP:    if (hit && req.wr) buf_we = req.wen;
      ACCESS:    if (req.wr) buf_we = req.wen;
      WB_REQ, WB_DATA, WB_WAIT:
                 buf_addr = wb_cnt[IDX_W-1:0] + IDX_W'(wb_adv);
      FILL_DATA: begin
        buf_addr  = fill_cnt[IDX_W-1:0];
        buf_wdata = i_blk_rdata;
        if (fill_wr) buf_we = 4'b1111;
      end
      default: ;
    endcase
  end

  sdcram_sector_buf #(.WORDS(SECTOR_WORDS)) u_buf (
    .i_clk (i_clk),
    .addr  (buf_addr),
    .we    (buf_we),
    .wdata (buf_wdata),
    .rdata (buf_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      req          <= '0;
      req_idx      <= '0;
      req_sec      <= '0;
      valid        <= 1'b0;
      dirty        <= 1'b0;
      done_seen    <= 1'b0;
      tag          <= '0;
      wb_cnt       <= '0;
      fill_cnt     <= '0;
      sdcram_busy  <= 1'b0;
      sdcram_rdata <= '0;
      o_blk_rd_req <= 1'b0;
      o_blk_wr_req <= 1'b0;
      o_blk_sector <= '0;
      o_blk_wvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          req.wr      <= (sdcram_wen != 4'b0000);
          req.wen     <= sdcram_wen;
          req.wdata   <= sdcram_wdata;
          req_idx     <= sdcram_addr[WORD_LSB +: IDX_W];
          req_sec     <= BLK_SEC_W'(sdcram_addr[ADDR_W-1:SEC_LSB]);
          sdcram_busy <= 1'b1;
          state       <= LOOKUP;
        end
        LOOKUP: begin
          done_seen <= 1'b0;
          if (hit) begin
            if (req.wr) dirty <= 1'b1;
            else        sdcram_rdata <= buf_rdata;
            sdcram_busy <= 1'b0;
            state       <= IDLE;
          end else if (dirty) begin
            o_blk_wr_req <= 1'b1;
            o_blk_sector <= tag;
            wb_cnt       <= '0;
            state        <= WB_REQ;
          end else begin
            o_blk_rd_req <= 1'b1;
            o_blk_sector <= req_sec;
            fill_cnt     <= '0;
            state        <= FILL_REQ;
          end
        end
        WB_REQ: if (i_blk_ack) begin
          o_blk_wr_req <= 1'b0;
          o_blk_wvalid <= 1'b1;
          state        <= WB_DATA;
        end
        WB_DATA: begin
          if (i_blk_done) done_seen <= 1'b1;
          if (wb_adv) begin
            wb_cnt <= wb_cnt + 1'b1;
            if (wb_cnt == LAST) begin
              o_blk_wvalid <= 1'b0;
              state        <= WB_WAIT;
            end
          end
        end
        WB_WAIT: if (i_blk_done || done_seen) begin
          dirty        <= 1'b0;
          done_seen    <= 1'b0;
          o_blk_rd_req <= 1'b1;
          o_blk_sector <= req_sec;
          fill_cnt     <= '0;
          state        <= FILL_REQ;
        end
        FILL_REQ: if (i_blk_ack) begin
          o_blk_rd_req <= 1'b0;
          state        <= FILL_DATA;
        end
        // a done pulse coinciding with the last word is remembered for FILL_WAIT
        FILL_DATA: begin
          if (i_blk_done) done_seen <= 1'b1;
          if (fill_wr) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == LAST) state <= FILL_WAIT;
          end
        end
        FILL_WAIT: if (i_blk_done || done_seen) begin
          tag       <= req_sec;
          valid     <= 1'b1;
          done_seen <= 1'b0;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (req.wr) dirty <= 1'b1;
          else        sdcram_rdata <= buf_rdata;
          sdcram_busy <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdcram_sector_cache.sv
// Directed bench for sdcram_sector_cache with a behavioural block backend.
module tb_sdcram_sector_cache;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [40:0] sdcram_addr;
  logic        sdcram_ren;
  logic [3:0]  sdcram_wen;
  logic [31:0] sdcram_wdata, sdcram_rdata;
  logic        sdcram_busy;
  logic        o_blk_rd_req, o_blk_wr_req, o_blk_wvalid;
  logic [31:0] o_blk_sector, o_blk_wdata;
  logic        i_blk_ack, i_blk_rvalid, i_blk_wready, i_blk_done;
  logic [31:0] i_blk_rdata;

  always #5 i_clk = ~i_clk;

  sdcram_sector_cache dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .sdcram_addr(sdcram_addr), .sdcram_ren(sdcram_ren), .sdcram_wen(sdcram_wen),
    .sdcram_wdata(sdcram_wdata), .sdcram_rdata(sdcram_rdata), .sdcram_busy(sdcram_busy),
    .o_blk_rd_req(o_blk_rd_req), .o_blk_wr_req(o_blk_wr_req), .o_blk_sector(o_blk_sector),
    .i_blk_ack(i_blk_ack), .i_blk_rdata(i_blk_rdata), .i_blk_rvalid(i_blk_rvalid),
    .o_blk_wdata(o_blk_wdata), .o_blk_wvalid(o_blk_wvalid), .i_blk_wready(i_blk_wready),
    .i_blk_done(i_blk_done)
  );

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fill_word(input logic [31:0] sec, input int i);
    return 32'hA000_0000 + ((sec - 32'd1) << 12) + 32'(i);
  endfunction

  // backend model state
  int          bk_st = 0, bk_idx = 0, wb_n = 0, fills = 0, wbs = 0;
  logic [31:0] fill_sec, wb_sec;
  logic [31:0] wb_buf [128];
  bit          done_last = 0, surplus = 0, tog = 0;

  initial begin
    i_blk_ack = 0; i_blk_rvalid = 0; i_blk_done = 0; i_blk_wready = 0; i_blk_rdata = '0;
    forever begin
      @(negedge i_clk);
      i_blk_ack = 0; i_blk_rvalid = 0; i_blk_done = 0; i_blk_wready = 0; i_blk_rdata = '0;
      if (i_rst) bk_st = 0;
      else case (bk_st)
        0: if (o_blk_rd_req) begin
             i_blk_ack = 1; fill_sec = o_blk_sector; fills++; bk_idx = 0; bk_st = 1;
           end else if (o_blk_wr_req) begin
             i_blk_ack = 1; wb_sec = o_blk_sector; wbs++; wb_n = 0; tog = 0; bk_st = 3;
           end
        1: begin
             i_blk_rvalid = 1; i_blk_rdata = fill_word(fill_sec, bk_idx); bk_idx++;
             if (bk_idx == 128) begin
               if (done_last) begin i_blk_done = 1; bk_st = 0; end
               else bk_st = 2;
             end
           end
        2: begin
             i_blk_done = 1;
             if (surplus) begin i_blk_rvalid = 1; i_blk_rdata = 32'hFFFF_FFFF; end
             bk_st = 0;
           end
        3: begin
             i_blk_wready = tog; tog = ~tog;
             if (o_blk_wvalid && i_blk_wready) begin
               if (wb_n < 128) wb_buf[wb_n] = o_blk_wdata;
               wb_n++;
               if (wb_n == 128) bk_st = 4;
             end
           end
        4: begin i_blk_done = 1; bk_st = 0; end
        default: bk_st = 0;
      endcase
    end
  end

  typedef struct {
    string       name;
    logic [40:0] addr;
    logic        ren;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_busy;   // 0 = not checked (miss)
    int          exp_fills;
    int          exp_wbs;
    logic [31:0] exp_sec;
    bit          done_last;
    bit          surplus;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int f0, w0, n;
    f0 = fills; w0 = wbs; done_last = v.done_last; surplus = v.surplus;
    @(negedge i_clk);
    sdcram_addr = v.addr; sdcram_ren = v.ren; sdcram_wen = v.wen; sdcram_wdata = v.wdata;
    @(negedge i_clk);
    sdcram_ren = 0; sdcram_wen = 4'b0000;
    n = 0;
    while (sdcram_busy && n < 5000) begin n++; @(negedge i_clk); end
    check({v.name, "_timeout"}, 32'(n >= 5000), 32'd0);
    check({v.name, "_rdata"}, sdcram_rdata, v.exp_rdata);
    if (v.exp_busy != 0) check({v.name, "_busy_cycles"}, 32'(n), 32'(v.exp_busy));
    check({v.name, "_fills"}, 32'(fills - f0), 32'(v.exp_fills));
    check({v.name, "_wbs"}, 32'(wbs - w0), 32'(v.exp_wbs));
    if (v.exp_fills != 0) check({v.name, "_fill_sector"}, fill_sec, v.exp_sec);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(sdcram_busy), 32'd0);
    check({tag, "_rdata"}, sdcram_rdata, 32'd0);
    check({tag, "_rd_req"}, 32'(o_blk_rd_req), 32'd0);
    check({tag, "_wr_req"}, 32'(o_blk_wr_req), 32'd0);
    check({tag, "_wvalid"}, 32'(o_blk_wvalid), 32'd0);
    check({tag, "_sector"}, o_blk_sector, 32'd0);
  endtask

  vec_t vecs [6];

  initial begin
    int n, bad;
    vecs[0] = '{"cold_rd",  41'h200, 1, 4'h0, 32'h0,         32'hA000_0000, 0, 1, 0, 32'd1, 0, 1};
    vecs[1] = '{"hit_rd",   41'h20C, 1, 4'h0, 32'h0,         32'hA000_0003, 1, 0, 0, 32'd0, 0, 0};
    vecs[2] = '{"hit_wr",   41'h204, 0, 4'h5, 32'h1122_3344, 32'hA000_0003, 1, 0, 0, 32'd0, 0, 0};
    vecs[3] = '{"merge_rd", 41'h204, 1, 4'h0, 32'h0,         32'hA022_0044, 1, 0, 0, 32'd0, 0, 0};
    vecs[4] = '{"wb_fill",  41'h400, 1, 4'h0, 32'h0,         32'hA000_1000, 0, 1, 1, 32'd2, 1, 0};
    vecs[5] = '{"hit_last", 41'h5FC, 1, 4'h0, 32'h0,         32'hA000_107F, 1, 0, 0, 32'd0, 0, 0};

    i_rst = 1; sdcram_addr = '0; sdcram_ren = 0; sdcram_wen = 4'b0000; sdcram_wdata = '0;
    @(negedge i_clk); @(negedge i_clk);
    check_reset_outputs("reset");
    i_rst = 0;

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // write-back contents of sector 1 in order, with the merged word 1
    check("wb_sector", wb_sec, 32'd1);
    check("wb_count", 32'(wb_n), 32'd128);
    bad = -1;
    for (int i = 0; i < 128; i++)
      if (bad < 0 && wb_buf[i] !== ((i == 1) ? 32'hA022_0044 : fill_word(32'd1, i))) bad = i;
    check("wb_order_first_bad", 32'(bad), 32'hFFFF_FFFF);

    // ren together with wen is a write; a read issued while busy is dropped
    @(negedge i_clk);
    sdcram_addr = 41'h400; sdcram_ren = 1; sdcram_wen = 4'hF; sdcram_wdata = 32'hDEAD_BEEF;
    @(negedge i_clk);
    sdcram_wen = 4'b0000; sdcram_addr = 41'h404;
    check("rw_busy", 32'(sdcram_busy), 32'd1);
    @(negedge i_clk);
    sdcram_ren = 0;
    check("rw_done", 32'(sdcram_busy), 32'd0);
    check("rw_ren_ignored", sdcram_rdata, 32'hA000_107F);
    @(negedge i_clk);
    check("busy_ren_dropped", 32'(sdcram_busy), 32'd0);
    run_vec('{"rw_rd0", 41'h400, 1, 4'h0, 32'h0, 32'hDEAD_BEEF, 1, 0, 0, 32'd0, 0, 0});
    run_vec('{"rw_rd1", 41'h404, 1, 4'h0, 32'h0, 32'hA000_1001, 1, 0, 0, 32'd0, 0, 0});

    // reset during the fill of sector 3 (after write-back of dirty sector 2)
    @(negedge i_clk);
    sdcram_addr = 41'h600; sdcram_ren = 1;
    @(negedge i_clk);
    sdcram_ren = 0;
    n = 0;
    while (!(bk_st == 1 && bk_idx == 50) && n < 2000) begin n++; @(negedge i_clk); end
    check("reach_word50_timeout", 32'(n >= 2000), 32'd0);
    i_rst = 1;
    @(negedge i_clk);
    check_reset_outputs("midfill_reset");
    @(negedge i_clk);
    i_rst = 0;
    run_vec('{"refill", 41'h600, 1, 4'h0, 32'h0, 32'hA000_2000, 0, 1, 0, 32'd3, 0, 0});
    run_vec('{"clean_miss", 41'h210, 1, 4'h0, 32'h0, 32'hA000_0004, 0, 1, 0, 32'd1, 0, 0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sdcram_sector_cache.md
Name: sdcram_sector_cache

Overview:
- Responder end of the sdcram bus (addr/ren/wen/wdata/rdata/busy) that the program loader and the sdcram controller drive as initiators.
- Holds one 512-byte sector in block RAM and serves word reads and byte-enabled writes from it.
- On a miss it writes the sector back if dirty, then fills the new sector from a sector-level block-device backend (SD host).
- Sits between the SD peripheral mux and the SD host engine.

Parameters:
- SECTOR_WORDS, 128, 32-bit words per sector; power of two; word index = addr[8:2] at default.
- ADDR_W, 41, sdcram byte-address width; sector number = addr[ADDR_W-1:9].

Ports:
- i_clk  in  1  sole clock
- i_rst  in  1  synchronous, active-high reset
- sdcram_addr  in  41  byte address; bits [1:0] ignored
- sdcram_ren  in  1  read request pulse
- sdcram_wen  in  4  byte enables; nonzero = write request
- sdcram_wdata  in  32  write data
- sdcram_rdata  out  32  read data; valid when busy falls, held until the next accepted read
- sdcram_busy  out  1  request in progress
- o_blk_rd_req  out  1  sector read request, level, held until i_blk_ack
- o_blk_wr_req  out  1  sector write request, level, held until i_blk_ack
- o_blk_sector  out  32  sector number for the current request
- i_blk_ack  in  1  backend accepted the request
- i_blk_rdata  in  32  fill word
- i_blk_rvalid  in  1  fill word valid
- o_blk_wdata  out  32  write-back word
- o_blk_wvalid  out  1  write-back word valid
- i_blk_wready  in  1  backend consumed o_blk_wdata
- i_blk_done  in  1  one-cycle pulse: backend finished the sector transaction

Behaviour:
- Reset values (i_rst high for one edge is sufficient): busy=0, rdata=0, all o_blk_* =0, valid=0, dirty=0, tag=0, state=IDLE.
- Reset mid-operation abandons any backend transaction immediately. Dirty data is lost.
- Acceptance: a request is accepted at edge T when busy=0 and (ren | wen!=0).
  - If ren and wen are both asserted, the request is a write; ren is ignored.
  - Requests while busy=1 are ignored, not queued.
  - Address, wen and wdata are latched at T.
- busy=1 from T+1 until completion.
- Hit latency: tag match and valid gives busy high for exactly one cycle.
  - Read: rdata updated at T+2, busy=0 at T+2.
  - Write: bytes with wen[i]=1 merged into the buffer word, dirty=1, busy=0 at T+2.
- States: IDLE, LOOKUP, WB_REQ, WB_DATA, WB_WAIT, FILL_REQ, FILL_DATA, FILL_WAIT, ACCESS.
  - IDLE: on accept, go to LOOKUP.
  - LOOKUP: on hit, do the access and go to IDLE.
  - LOOKUP: on miss with dirty=1, go to WB_REQ; otherwise go to FILL_REQ.
  - WB_REQ: o_blk_wr_req=1, o_blk_sector=old tag. On i_blk_ack, go to WB_DATA.
  - WB_DATA: stream words 0..SECTOR_WORDS-1 on o_blk_wdata. A word advances on wvalid & wready. The buffer read is pipelined so that wvalid never presents a stale word. After the last word, go to WB_WAIT.
  - WB_WAIT: on i_blk_done, set dirty=0 and go to FILL_REQ.
  - FILL_REQ: o_blk_rd_req=1, o_blk_sector=new sector. On i_blk_ack, go to FILL_DATA.
  - FILL_DATA: each i_blk_rvalid writes the word at the fill counter and increments the counter. After SECTOR_WORDS words, go to FILL_WAIT.
  - FILL_WAIT: on i_blk_done, set tag=new, valid=1, go to ACCESS.
  - ACCESS: perform the latched read or write as on a hit, then go to IDLE with busy=0 next cycle.
- Boundary conditions:
  - i_blk_done arriving in the same cycle as the last rvalid is legal and is treated as both.
  - i_blk_rvalid outside FILL_DATA is ignored.
  - A surplus rvalid beyond SECTOR_WORDS is ignored.
  - Counters are SECTOR_WORDS-wide index plus a terminal flag; no wrap into a second pass.
  - Sector number is addr[40:9], zero-extended to 32 bits.
  - Writes with wen=4'b0000 are not requests.

Decomposition:
- Shared package/header: state encodings, SECTOR_WORDS default, and sdcram field-slice constants (word index and sector bits).
- One sub-module, sdcram_sector_buf: single-port synchronous-read RAM of SECTOR_WORDS×32 with per-byte write enables.

Test Plan:
- Cold read of addr 0x200 → o_blk_rd_req with sector=1, no write-back.
  - Backend supplies words 0xA000_0000+i → rdata=0xA000_0000 when busy falls.
  - Busy duration = fill time + 2.
- Hit read of addr 0x20C after the fill → busy exactly one cycle, rdata=0xA000_0003, no backend activity.
- Write wen=4'b0101, wdata=0x11223344 to 0x204, then read 0x204 → rdata=0xA022_0044, dirty=1.
- Read addr 0x400 while dirty → write-back of sector 1 (word 1 = 0xA022_0044), then fill of sector 2.
  - i_blk_wready toggled every other cycle → all 128 words transferred in order.
- ren=1 with wen=4'b1111 in the same cycle → treated as a write; a second ren while busy is dropped.
- i_rst asserted during FILL_DATA at word 50 → all outputs return to reset values next edge, valid=0; the next read restarts a full fill.
